seg_scan: RTL



---
 rtl/seg_pkg.sv | 21 ++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/seg_scan.sv | 97 +++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 decode to an unlit digit.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scan driver for a common-anode display,
// with frame-synchronous input snapshot, inter-digit blanking and optional LZ suppression.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int LZ_BLANK  = 0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int              CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   BLANK_LIM = CW'(BLANK_CYC);

  logic [CW-1:0]   cnt_reg;
  digit_idx_t      idx_reg;
  logic [3:0][3:0] shadow_reg;
  logic [3:0]      shadow_dp_reg;

  logic [3:0][6:0] dec_seg;
  logic [3:0]      lz_sup;
  logic            snap;
  logic            blanking;
  logic [3:0]      an_next;
  logic [6:0]      seg_next;
  logic            dp_next;

  assign snap     = (cnt_reg == '0) && (idx_reg == 2'd0);
  assign blanking = (cnt_reg < BLANK_LIM);

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    bcd_to_seg u_dec (
      .bcd (shadow_reg[gi]),
      .seg (dec_seg[gi])
    );
  end

  // Suppression cascades from the leftmost digit; digit 0 always shows.
  always_comb begin
    lz_sup    = 4'b0000;
    lz_sup[3] = (LZ_BLANK != 0) && (shadow_reg[3] == 4'd0);
    lz_sup[2] = lz_sup[3] && (shadow_reg[2] == 4'd0);
    lz_sup[1] = lz_sup[2] && (shadow_reg[1] == 4'd0);
  end

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (!blanking) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = lz_sup[idx_reg] ? SEG_BLANK : dec_seg[idx_reg];
      dp_next  = ~shadow_dp_reg[idx_reg];
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      idx_reg       <= 2'd0;
      shadow_reg    <= '0;
      shadow_dp_reg <= 4'b0000;
      an            <= AN_OFF;
      seg           <= SEG_BLANK;
      dp            <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      if (cnt_reg == CNT_MAX) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (snap) begin
        shadow_reg    <= {d3, d2, d1, d0};
        shadow_dp_reg <= dp_en;
      end
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_tick <= snap;
    end
  end

endmodule
